pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage RISC-V core. It drives the enable, bubble and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards between ID and EX and squashes the wrong-path instructions on a taken branch resolved in EX. It also freezes the whole pipe while a data-memory access is not ready, with a timeout monitor. The ID/EX register consumes `idex_bubble` by loading zeros into `pcsrc`, `alusrc`, `memtoreg`, `we` and `reg_en` instead of the decoded values.

---
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/sequencing bundle between the pipeline datapath and pipe_hazard_ctrl.
// master = datapath side (drives hazard info, consumes controls); slave = controller.
interface pipe_hazard_ctrl_if;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_uses_rs1;
   logic        id_uses_rs2;
   logic [4:0]  ex_rd;
   logic        ex_memtoreg;
   logic        ex_reg_en;
   logic        ex_pcsrc;
   logic        mem_req;
   logic        mem_ready;
   logic        pc_en;
   logic        ifid_en;
   logic        idex_en;
   logic        exmem_en;
   logic        ifid_flush;
   logic        idex_bubble;
   logic        memwb_bubble;
   logic [1:0]  state;
   logic        mem_timeout;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memtoreg,
             ex_reg_en, ex_pcsrc, mem_req, mem_ready,
      input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble,
             memwb_bubble, state, mem_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memtoreg,
             ex_reg_en, ex_pcsrc, mem_req, mem_ready,
      output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble,
             memwb_bubble, state, mem_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipe sequencer: load-use stall, EX branch flush, memory-wait freeze.
// Optional performance counters are built only when PIPE_PERF_EN is defined.
module pipe_hazard_ctrl #(
   parameter int unsigned LU_STALL_CYCLES = 1,
   parameter int unsigned MAX_WAIT        = 15
) (
   input logic              clock,
   input logic              reset_n,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int unsigned STALL_W = 3;
   localparam int unsigned WAIT_W  = 8;
   localparam int unsigned CNT_W   = 32;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [STALL_W-1:0]  stall_q, stall_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                timeout_q, timeout_d;

   logic lu_c, mem_wait_c;
   logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c;
   logic ifid_flush_c, idex_bubble_c, memwb_bubble_c;

   assign lu_c = bus.ex_memtoreg & bus.ex_reg_en & (bus.ex_rd != 5'd0) &
                 ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                  (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));
   assign mem_wait_c = bus.mem_req & ~bus.mem_ready;

   // State and counter registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= RUN;
         stall_q   <= '0;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         stall_q   <= stall_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
      end
   end

   // Next state and control outputs
   always_comb begin
      state_d        = state_q;
      stall_d        = stall_q;
      wait_d         = wait_q;
      timeout_d      = timeout_q;
      pc_en_c        = 1'b1;
      ifid_en_c      = 1'b1;
      idex_en_c      = 1'b1;
      exmem_en_c     = 1'b1;
      ifid_flush_c   = 1'b0;
      idex_bubble_c  = 1'b0;
      memwb_bubble_c = 1'b0;

      case (state_q)
         RUN: begin
            if (mem_wait_c) begin
               pc_en_c        = 1'b0;
               ifid_en_c      = 1'b0;
               idex_en_c      = 1'b0;
               exmem_en_c     = 1'b0;
               memwb_bubble_c = 1'b1;
               state_d        = MEM_WAIT;
               wait_d         = WAIT_W'(1);
               if (MAX_WAIT <= 1) timeout_d = 1'b1;
            end else if (bus.ex_pcsrc) begin
               ifid_flush_c  = 1'b1;
               idex_bubble_c = 1'b1;
            end else if (lu_c) begin
               pc_en_c       = 1'b0;
               ifid_en_c     = 1'b0;
               idex_bubble_c = 1'b1;
               if (LU_STALL_CYCLES > 1) begin
                  state_d = LU_STALL;
                  stall_d = STALL_W'(LU_STALL_CYCLES - 1);
               end
            end
         end
         LU_STALL: begin
            // A memory wait freezes the stall count without leaving the state
            if (mem_wait_c) begin
               pc_en_c        = 1'b0;
               ifid_en_c      = 1'b0;
               idex_en_c      = 1'b0;
               exmem_en_c     = 1'b0;
               memwb_bubble_c = 1'b1;
            end else begin
               pc_en_c       = 1'b0;
               ifid_en_c     = 1'b0;
               idex_bubble_c = 1'b1;
               stall_d       = stall_q - STALL_W'(1);
               if (stall_q <= STALL_W'(1)) state_d = RUN;
            end
         end
         MEM_WAIT: begin
            if (bus.mem_ready) begin
               state_d = RUN;
            end else begin
               pc_en_c        = 1'b0;
               ifid_en_c      = 1'b0;
               idex_en_c      = 1'b0;
               exmem_en_c     = 1'b0;
               memwb_bubble_c = 1'b1;
               if (wait_q != {WAIT_W{1'b1}}) wait_d = wait_q + WAIT_W'(1);
               if ((CNT_W'(wait_q) + CNT_W'(1)) >= MAX_WAIT) timeout_d = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase

      // Hold the whole pipe empty while reset is asserted
      if (!reset_n) begin
         pc_en_c        = 1'b0;
         ifid_en_c      = 1'b0;
         idex_en_c      = 1'b0;
         exmem_en_c     = 1'b0;
         ifid_flush_c   = 1'b1;
         idex_bubble_c  = 1'b1;
         memwb_bubble_c = 1'b1;
      end
   end

   assign bus.pc_en        = pc_en_c;
   assign bus.ifid_en      = ifid_en_c;
   assign bus.idex_en      = idex_en_c;
   assign bus.exmem_en     = exmem_en_c;
   assign bus.ifid_flush   = ifid_flush_c;
   assign bus.idex_bubble  = idex_bubble_c;
   assign bus.memwb_bubble = memwb_bubble_c;
   assign bus.state        = state_q;
   assign bus.mem_timeout  = timeout_q;

`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // Free-running wrap-around event counters
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!pc_en_c)     stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (ifid_flush_c) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`else
   assign bus.stall_cnt = '0;
   assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: u_dut1 uses default parameters,
// u_dut3 uses LU_STALL_CYCLES=3; both see identical inputs.
module tb_pipe_hazard_ctrl;
   localparam logic [6:0] NORM = 7'b1111000;
   localparam logic [6:0] LUS  = 7'b0011010;
   localparam logic [6:0] FLS  = 7'b1111110;
   localparam logic [6:0] FRZ  = 7'b0000001;
   localparam logic [6:0] RSTV = 7'b0000111;

   logic clock;
   logic reset_n;
   int   checks;
   int   errors;
   int   exp_stall;
   int   exp_flush;
   int   pc_low3;
   logic [6:0] cur_exp1;

   pipe_hazard_ctrl_if if1 ();
   pipe_hazard_ctrl_if if3 ();

   assign if3.id_rs1      = if1.id_rs1;
   assign if3.id_rs2      = if1.id_rs2;
   assign if3.id_uses_rs1 = if1.id_uses_rs1;
   assign if3.id_uses_rs2 = if1.id_uses_rs2;
   assign if3.ex_rd       = if1.ex_rd;
   assign if3.ex_memtoreg = if1.ex_memtoreg;
   assign if3.ex_reg_en   = if1.ex_reg_en;
   assign if3.ex_pcsrc    = if1.ex_pcsrc;
   assign if3.mem_req     = if1.mem_req;
   assign if3.mem_ready   = if1.mem_ready;

   pipe_hazard_ctrl #(.LU_STALL_CYCLES(1), .MAX_WAIT(15)) u_dut1 (
      .clock(clock), .reset_n(reset_n), .bus(if1));
   pipe_hazard_ctrl #(.LU_STALL_CYCLES(3), .MAX_WAIT(15)) u_dut3 (
      .clock(clock), .reset_n(reset_n), .bus(if3));

   wire [6:0] ctl1 = {if1.pc_en, if1.ifid_en, if1.idex_en, if1.exmem_en,
                      if1.ifid_flush, if1.idex_bubble, if1.memwb_bubble};
   wire [6:0] ctl3 = {if3.pc_en, if3.ifid_en, if3.idex_en, if3.exmem_en,
                      if3.ifid_flush, if3.idex_bubble, if3.memwb_bubble};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic [6:0] exp_ctl, input logic [1:0] exp_st);
      cur_exp1 = exp_ctl;
      chk({tag, "_ctl1"}, 32'(ctl1), 32'(exp_ctl));
      chk({tag, "_st1"}, 32'(if1.state), 32'(exp_st));
   endtask

   task automatic chk3(input string tag, input logic [6:0] exp_ctl, input logic [1:0] exp_st);
      chk({tag, "_ctl3"}, 32'(ctl3), 32'(exp_ctl));
      chk({tag, "_st3"}, 32'(if3.state), 32'(exp_st));
   endtask

   task automatic chk_cnt(input string tag);
`ifdef PIPE_PERF_EN
      chk({tag, "_stall_cnt"}, if1.stall_cnt, 32'(exp_stall));
      chk({tag, "_flush_cnt"}, if1.flush_cnt, 32'(exp_flush));
`else
      chk({tag, "_stall_cnt"}, if1.stall_cnt, 32'd0);
      chk({tag, "_flush_cnt"}, if1.flush_cnt, 32'd0);
`endif
   endtask

   // Advance one cycle, accounting expected counter events of the ending cycle
   task automatic tick();
      if (reset_n) begin
         if (!cur_exp1[6]) exp_stall++;
         if (cur_exp1[2])  exp_flush++;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic set_hazard(input logic [4:0] rd, input logic [4:0] rs2);
      if1.ex_memtoreg = 1'b1;
      if1.ex_reg_en   = 1'b1;
      if1.ex_rd       = rd;
      if1.id_rs2      = rs2;
      if1.id_uses_rs2 = 1'b1;
   endtask

   task automatic clr_hazard();
      if1.ex_memtoreg = 1'b0;
      if1.ex_reg_en   = 1'b0;
      if1.ex_rd       = 5'd0;
      if1.id_rs2      = 5'd0;
      if1.id_uses_rs2 = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0; exp_stall = 0; exp_flush = 0; pc_low3 = 0;
      cur_exp1 = RSTV;
      reset_n = 1'b0;
      if1.id_rs1 = 5'd0; if1.id_uses_rs1 = 1'b0;
      clr_hazard();
      if1.ex_pcsrc = 1'b0; if1.mem_req = 1'b0; if1.mem_ready = 1'b0;

      // Reset state
      #3;
      chk1("reset", RSTV, 2'd0);
      chk("reset_timeout", 32'(if1.mem_timeout), 32'd0);
      chk_cnt("reset");
      @(posedge clock); #1;
      reset_n = 1'b1;
      #2;
      chk1("run_idle", NORM, 2'd0);
      chk3("run_idle", NORM, 2'd0);
      tick();

      // Load-use on rs2
      set_hazard(5'd5, 5'd5); #2;
      chk1("lu_c0", LUS, 2'd0);
      chk3("lu_c0", LUS, 2'd0);
      tick();
      clr_hazard(); #2;
      chk1("lu_c1", NORM, 2'd0);
      chk3("lu_c1", LUS, 2'd1);
      tick(); #2;
      chk1("lu_c2", NORM, 2'd0);
      chk3("lu_c2", LUS, 2'd1);
      tick(); #2;
      chk1("lu_c3", NORM, 2'd0);
      chk3("lu_c3", NORM, 2'd0);
      tick();

      // x0 destination never hazards
      set_hazard(5'd0, 5'd0); #2;
      chk1("lu_x0", NORM, 2'd0);
      chk3("lu_x0", NORM, 2'd0);
      tick();
      clr_hazard();

      // Flush wins over simultaneous load-use (rs1 path)
      if1.ex_memtoreg = 1'b1; if1.ex_reg_en = 1'b1; if1.ex_rd = 5'd9;
      if1.id_rs1 = 5'd9; if1.id_uses_rs1 = 1'b1; if1.ex_pcsrc = 1'b1; #2;
      chk1("flush", FLS, 2'd0);
      chk3("flush", FLS, 2'd0);
      chk_cnt("pre_flush");
      tick();
      clr_hazard(); if1.id_rs1 = 5'd0; if1.id_uses_rs1 = 1'b0; if1.ex_pcsrc = 1'b0; #2;
      chk1("post_flush", NORM, 2'd0);
      chk3("post_flush", NORM, 2'd0);
      chk_cnt("post_flush");
      tick();

      // Memory wait: 4 cycles low, then ready
      if1.mem_req = 1'b1; if1.mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk1("mw_frz", FRZ, (i == 0) ? 2'd0 : 2'd2);
         chk3("mw_frz", FRZ, (i == 0) ? 2'd0 : 2'd2);
         tick();
      end
      if1.mem_ready = 1'b1; #2;
      chk1("mw_release", NORM, 2'd2);
      chk("mw_timeout", 32'(if1.mem_timeout), 32'd0);
      tick();
      if1.mem_req = 1'b0; if1.mem_ready = 1'b0; #2;
      chk1("mw_after", NORM, 2'd0);
      chk_cnt("mw_after");
      tick();

      // LU_STALL interrupted by a 2-cycle memory wait (u_dut3)
      set_hazard(5'd7, 5'd7); #2;
      chk1("lmw_c0", LUS, 2'd0);
      chk3("lmw_c0", LUS, 2'd0);
      if (!if3.pc_en) pc_low3++;
      tick();
      clr_hazard(); if1.mem_req = 1'b1; if1.mem_ready = 1'b0; #2;
      chk1("lmw_c1", FRZ, 2'd0);
      chk3("lmw_c1", FRZ, 2'd1);
      if (!if3.pc_en) pc_low3++;
      tick(); #2;
      chk1("lmw_c2", FRZ, 2'd2);
      chk3("lmw_c2", FRZ, 2'd1);
      if (!if3.pc_en) pc_low3++;
      tick();
      if1.mem_ready = 1'b1; #2;
      chk1("lmw_c3", NORM, 2'd2);
      chk3("lmw_c3", LUS, 2'd1);
      if (!if3.pc_en) pc_low3++;
      tick();
      if1.mem_req = 1'b0; if1.mem_ready = 1'b0; #2;
      chk1("lmw_c4", NORM, 2'd0);
      chk3("lmw_c4", LUS, 2'd1);
      if (!if3.pc_en) pc_low3++;
      tick(); #2;
      chk1("lmw_c5", NORM, 2'd0);
      chk3("lmw_c5", NORM, 2'd0);
      if (!if3.pc_en) pc_low3++;
      chk("lmw_pc_low_total", 32'(pc_low3), 32'd5);
      chk_cnt("lmw_after");
      tick();

      // Timeout: ready held low 20 cycles; sticky from the 15th MEM_WAIT cycle
      if1.mem_req = 1'b1; if1.mem_ready = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         #2;
         chk1("to_frz", FRZ, (k == 1) ? 2'd0 : 2'd2);
         chk("to_flag", 32'(if1.mem_timeout), (k >= 16) ? 32'd1 : 32'd0);
         tick();
      end
      chk_cnt("to_end");

      // Asynchronous reset mid-wait
      reset_n = 1'b0; #1;
      exp_stall = 0; exp_flush = 0;
      chk1("rst_mid", RSTV, 2'd0);
      chk3("rst_mid", RSTV, 2'd0);
      chk("rst_mid_timeout", 32'(if1.mem_timeout), 32'd0);
      chk_cnt("rst_mid");
      #2;
      reset_n = 1'b1; if1.mem_req = 1'b0; #1;
      chk1("rst_after", NORM, 2'd0);
      tick(); #2;
      chk1("rst_run", NORM, 2'd0);
      chk("rst_run_timeout", 32'(if1.mem_timeout), 32'd0);
      chk_cnt("rst_run");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      errors++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end
endmodule
